// File: rtl/bootrom_pkg.sv
// Shared types and constants for the BootROM bus adapter.
// Holds the FSM encoding and the size-to-beat-count helper.
package bootrom_pkg;

    localparam int BYTES_PER_BEAT = 4;
    localparam int MAX_SIZE       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Sub-word sizes still cost one full beat; 8 B and 16 B map to 2 and 4 beats.
    function automatic logic [2:0] beats_from_size(input logic [2:0] size);
        case (size)
            3'd3:    return 3'd2;
            3'd4:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/bootrom_tl_adapter.sv
// A/D channel front end for the BootROM macro: one FSM plus datapath.
// Legal reads stream 1-4 words at 1 beat/cycle; illegal reads get one error beat.
module bootrom_tl_adapter
    import bootrom_pkg::*;
#(
    parameter int WORD_ADDR_W = 11,
    parameter int DATA_W      = 32,
    parameter int BYTE_ADDR_W = WORD_ADDR_W + 2,
    parameter int SOURCE_W    = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [BYTE_ADDR_W-1:0] a_address,
    input  logic [2:0]             a_size,
    input  logic [SOURCE_W-1:0]    a_source,
    output logic                   d_valid,
    input  logic                   d_ready,
    output logic [DATA_W-1:0]      d_data,
    output logic [SOURCE_W-1:0]    d_source,
    output logic                   d_error,
    output logic                   d_last,
    output logic                   rom_me,
    output logic                   rom_oe,
    output logic [WORD_ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0]      rom_q,
    output logic [1:0]             dbg_state
);

    localparam int LANE_BITS = $clog2(BYTES_PER_BEAT);

    // Handshake rule on both channels: a transfer happens on a rising clock edge
    // where valid && ready; once d_valid is raised, d_data/d_source/d_error/d_last
    // stay stable until that transfer, and valid never drops without one.

    state_e                 state_q, state_d;
    logic [WORD_ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]             remaining_q, remaining_d;
    logic [SOURCE_W-1:0]    src_q, src_d;
    logic                   d_valid_q, d_valid_d;
    logic                   d_error_q, d_error_d;
    logic                   d_last_q, d_last_d;
    logic                   rom_oe_q, rom_oe_d;

    logic                   me_raw;
    logic                   a_legal;
    logic [4:0]             align_mask;
    logic [2:0]             beats_m1;
    logic [WORD_ADDR_W-1:0] a_word;
    logic [WORD_ADDR_W-1:0] ptr_inc;

    assign a_word     = a_address[BYTE_ADDR_W-1:LANE_BITS];
    assign ptr_inc    = ptr_q + WORD_ADDR_W'(1);
    assign align_mask = (5'd1 << a_size) - 5'd1;
    assign a_legal    = (a_size <= 3'(MAX_SIZE)) && ((a_address[3:0] & align_mask[3:0]) == 4'd0);
    assign beats_m1   = beats_from_size(a_size) - 3'd1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        src_d       = src_q;
        me_raw      = 1'b0;
        rom_address = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (a_valid) begin
                    src_d = a_source;
                    if (a_legal) begin
                        me_raw      = 1'b1;
                        rom_address = a_word;
                        ptr_d       = a_word;
                        remaining_d = beats_m1[1:0];
                        state_d     = ST_BEAT;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_BEAT: begin
                if (d_ready) begin
                    if (remaining_q != 2'd0) begin
                        // Fetch the next word while this one is consumed: no bubbles.
                        me_raw      = 1'b1;
                        rom_address = ptr_inc;
                        ptr_d       = ptr_inc;
                        remaining_d = remaining_q - 2'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                if (d_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        d_valid_d = (state_d != ST_IDLE);
        d_error_d = (state_d == ST_ERR);
        rom_oe_d  = (state_d == ST_BEAT);
        d_last_d  = (state_d == ST_ERR) || ((state_d == ST_BEAT) && (remaining_d == 2'd0));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            src_q       <= '0;
            d_valid_q   <= 1'b0;
            d_error_q   <= 1'b0;
            d_last_q    <= 1'b0;
            rom_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            src_q       <= src_d;
            d_valid_q   <= d_valid_d;
            d_error_q   <= d_error_d;
            d_last_q    <= d_last_d;
            rom_oe_q    <= rom_oe_d;
        end
    end

    // The reset gate keeps the ROM idle and the A channel closed while reset_n is low.
    assign a_ready   = reset_n && (state_q == ST_IDLE);
    assign rom_me    = reset_n && me_raw;
    assign rom_oe    = rom_oe_q;
    assign d_valid   = d_valid_q;
    assign d_error   = d_error_q;
    assign d_last    = d_last_q;
    assign d_source  = src_q;
    assign d_data    = rom_oe_q ? rom_q : '0;
    assign dbg_state = state_q;

endmodule

// File: doc/bootrom_tl_adapter.md
Name: bootrom_tl_adapter

Overview:
- Bus-side front end for the BootROM macro (11-bit word address, 32-bit q, `me` enable, `oe` output enable, 1-cycle registered read).
- Accepts read requests on a valid/ready A channel and drives the ROM's `me`/`oe`/address.
- Returns ROM words as 1–4 response beats on a valid/ready D channel, at 1 beat/cycle when D is not stalled.
- Rejects illegal requests with an error beat and never touches the ROM for them.

Parameters:
- WORD_ADDR_W, 11, ROM word-address width.
- DATA_W, 32, ROM / D-channel data width (bytes per beat = 4).
- BYTE_ADDR_W, 13, A-channel byte-address width (= WORD_ADDR_W + 2).
- SOURCE_W, 4, request tag width, echoed on every response beat.
- MAX_SIZE, 4, largest legal log2(bytes) (16 B = 4 beats).

Ports:
- clock  in  1  sole clock, all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  request valid.
- a_ready  out  1  request accepted when a_valid && a_ready.
- a_address  in  BYTE_ADDR_W  request byte address.
- a_size  in  3  log2 of request bytes.
- a_source  in  SOURCE_W  request tag.
- d_valid  out  1  response beat valid.
- d_ready  in  1  response beat consumed when d_valid && d_ready.
- d_data  out  DATA_W  response word.
- d_source  out  SOURCE_W  echoed tag.
- d_error  out  1  illegal request; d_data = 0.
- d_last  out  1  final beat of the response.
- rom_me  out  1  ROM read enable.
- rom_oe  out  1  ROM output enable.
- rom_address  out  WORD_ADDR_W  ROM word address.
- rom_q  in  DATA_W  ROM data (high-Z when rom_oe = 0).

Behaviour:
- FSM states: IDLE, BEAT, ERR. Reset state: IDLE.
- Registers: word pointer `ptr` (WORD_ADDR_W), `remaining` (2 bits), `src`.
- While reset_n is low:
  - a_ready, d_valid, rom_me, rom_oe, d_error and d_last are all 0.
  - ptr, remaining and src are 0.
  - Reset assertion mid-burst aborts the burst immediately; no further beats are produced.
- Legality (evaluated in IDLE):
  - a_size must be ≤ MAX_SIZE.
  - a_address must be aligned to 2^a_size, i.e. the low a_size bits are 0.
- Beat count: beats = 1 when a_size ≤ 2; otherwise 2^(a_size−2).
  - Sub-word sizes return the full aligned word; lane selection is the master's job.
- IDLE:
  - a_ready = 1 (reset_n high).
  - On a legal accept:
    - rom_me = 1 combinationally in the accept cycle.
    - rom_address = a_address[BYTE_ADDR_W-1:2].
    - ptr ← that address; remaining ← beats−1; src ← a_source; next state BEAT.
  - On an illegal accept: rom_me stays 0; src ← a_source; next state ERR.
- BEAT:
  - a_ready = 0, d_valid = 1, rom_oe = 1.
  - d_data = rom_q (the ROM output register holds its value until the next me).
  - d_source = src; d_error = 0; d_last = (remaining == 0).
  - On d_ready with remaining ≠ 0:
    - rom_me = 1 and rom_address = ptr+1 in the same cycle.
    - ptr ← ptr+1; remaining ← remaining−1; stay in BEAT.
    - Result: back-to-back beats with zero bubbles.
  - On d_ready with remaining == 0: go to IDLE.
  - On d_ready low: rom_me = 0 and all D outputs are held stable (valid/data stability rule).
- ERR:
  - d_valid = 1, d_error = 1, d_data = 0, d_last = 1, d_source = src, rom_oe = 0.
  - On d_ready go to IDLE.
- No new request is accepted in the cycle that the last beat is consumed. Minimum request-to-request spacing is beats+1 cycles.
- Latency: accept at cycle N → first d_valid at N+1.
- rom_me is never asserted outside the two cases above; rom_oe = 1 only in BEAT.
- Address arithmetic: aligned bursts never cross a 16 B boundary, so ptr+1 never wraps within a burst. The top word address 0x7FF is valid for single-beat reads.

Decomposition:
- Shared package bootrom_pkg holds:
  - the FSM state enum (IDLE/BEAT/ERR);
  - the bytes-per-beat constant;
  - a beats_from_size function;
  - the MAX_SIZE constant.
- No sub-module. The block is a single FSM plus datapath; the ROM macro is instantiated alongside it by the parent, not inside it.

Test Plan:
- ROM preload: word i = 0xB000_0000 | i. d_ready held high unless a scenario says otherwise.
- Single word: a_address 0x0010, a_size 2, a_source 3 → one beat with d_data 0xB000_0004, d_source 3, d_last 1, d_error 0, arriving one cycle after accept; rom_me pulses exactly once.
- Burst, no stall: a_address 0x0020, a_size 4 → four consecutive beats 0xB000_0008..0xB000_000B on cycles N+1..N+4; d_last only on the 4th beat; a_ready returns at N+5.
- Burst with stall: same request, d_ready low for 3 cycles on beat 2 → d_data holds 0xB000_0009 throughout, rom_me stays 0 during the stall, total 4 beats with no duplicates or drops.
- Illegal requests:
  - a_address 0x0022, a_size 2 (misaligned) → single beat with d_error 1, d_data 0, d_last 1; rom_me never asserted.
  - a_size 5 → same error response.
- Reset mid-burst: drop reset_n after beat 2 of a 4-beat burst → d_valid falls to 0 asynchronously and rom_me is 0. After reset release, a_ready is 1 and a new single read at 0x1FFC returns 0xB000_07FF.
